// File: rtl/aluo_issue_reg_pkg.sv
// aluo_issue_reg_pkg
// Shared widths, opcode values and the packed issue-entry type for the
// issue-to-execute register that feeds the ALUO stage.
// BUBBLE_OPCODE is the opcode ALUO sees when no valid operation is held.
// It is deliberately outside the defined opcode set.
package aluo_issue_reg_pkg;

  localparam int PC_W    = 64;
  localparam int INST_W  = 32;
  localparam int TYPE_W  = 8;
  localparam int OPC_W   = 8;
  localparam int RADDR_W = 5;

  localparam int ISSUE_ENTRY_W = PC_W + INST_W + TYPE_W + OPC_W + PC_W + PC_W + 1 + RADDR_W; // 246

  localparam logic [OPC_W-1:0] BUBBLE_OPCODE = 8'h00;

  // Defined internal opcodes (never 8'h00)
  localparam logic [OPC_W-1:0] OP_ADD  = 8'h01;
  localparam logic [OPC_W-1:0] OP_SUB  = 8'h02;
  localparam logic [OPC_W-1:0] OP_ADDI = 8'h03;
  localparam logic [OPC_W-1:0] OP_MUL  = 8'h10;
  localparam logic [OPC_W-1:0] OP_DIV  = 8'h11;
  localparam logic [OPC_W-1:0] OP_CSR  = 8'h20;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INST_W-1:0]  inst;
    logic [TYPE_W-1:0]  itype;   // bit 7 = CSR/system class
    logic [OPC_W-1:0]   opcode;
    logic [PC_W-1:0]    op1;
    logic [PC_W-1:0]    op2;
    logic               rd_ena;
    logic [RADDR_W-1:0] rd_addr;
  } issue_entry_t;

  // All-zero payload with BUBBLE_OPCODE: what ALUO must see when idle
  function automatic issue_entry_t bubble_entry();
    issue_entry_t e;
    e        = '0;
    e.opcode = BUBBLE_OPCODE;
    return e;
  endfunction

  // Saturating 32-bit increment for the performance counters
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    logic [31:0] r;
    if (v == 32'hFFFF_FFFF) begin
      r = v;
    end else begin
      r = v + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/aluo_issue_reg_if.sv
// aluo_issue_reg_if
// Issue-side handshake/payload (in_*) and the ALUO-facing payload (out_*).
// Modports:
//   master - issue stage / ALUO side: drives in_*, observes in_ready and out_*
//   slave  - aluo_issue_reg: consumes in_*, drives in_ready and out_*
interface aluo_issue_reg_if;
  import aluo_issue_reg_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INST_W-1:0]  in_inst;
  logic [TYPE_W-1:0]  in_type;
  logic [OPC_W-1:0]   in_opcode;
  logic [PC_W-1:0]    in_op1;
  logic [PC_W-1:0]    in_op2;
  logic               in_rd_ena;
  logic [RADDR_W-1:0] in_rd_addr;

  logic               out_valid;
  logic [PC_W-1:0]    out_pc;
  logic [INST_W-1:0]  out_inst;
  logic [TYPE_W-1:0]  out_type;
  logic [OPC_W-1:0]   out_opcode;
  logic [PC_W-1:0]    out_op1;
  logic [PC_W-1:0]    out_op2;
  logic               out_rd_ena;
  logic [RADDR_W-1:0] out_rd_addr;

  modport master (
    output in_valid, in_pc, in_inst, in_type, in_opcode, in_op1, in_op2, in_rd_ena, in_rd_addr,
    input  in_ready,
    input  out_valid, out_pc, out_inst, out_type, out_opcode, out_op1, out_op2, out_rd_ena, out_rd_addr
  );

  modport slave (
    input  in_valid, in_pc, in_inst, in_type, in_opcode, in_op1, in_op2, in_rd_ena, in_rd_addr,
    output in_ready,
    output out_valid, out_pc, out_inst, out_type, out_opcode, out_op1, out_op2, out_rd_ena, out_rd_addr
  );

endinterface

// File: rtl/aluo_issue_entry.sv
// aluo_issue_entry
// One valid bit plus issue payload. clr has priority over load; otherwise
// the entry holds. A cleared entry carries the bubble payload so that the
// main instance can drive ALUO straight from its register.
// Ports: clk, rst (async active-low), load, clr, d (payload in),
//        valid, q (registered payload out)
module aluo_issue_entry
  import aluo_issue_reg_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr,
  input  issue_entry_t d,
  output logic         valid,
  output issue_entry_t q
);

  logic         valid_r;
  issue_entry_t q_r;

  // Entry register: clear to bubble, load new payload, or hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= 1'b0;
      q_r     <= bubble_entry();
    end else if (clr) begin
      valid_r <= 1'b0;
      q_r     <= bubble_entry();
    end else if (load) begin
      valid_r <= 1'b1;
      q_r     <= d;
    end else begin
      valid_r <= valid_r;
      q_r     <= q_r;
    end
  end

  assign valid = valid_r;
  assign q     = q_r;

endmodule

// File: rtl/aluo_issue_reg.sv
// aluo_issue_reg
// Issue-to-execute pipeline register with a 2-entry skid buffer in front of
// ALUO. The main entry drives ALUO; the skid entry absorbs one operation
// accepted while ALUO's mul/div is busy. A trap flush drops both entries.
// Ports:
//   clk, rst (async active-low)
//   flush_i   - trap flush from ALUO
//   ex_busy_i - ALUO mul/div busy; ignored while main is empty
//   bus       - aluo_issue_reg_if.slave: in_* handshake/payload, out_* to ALUO
//   perf_*    - stall/bubble/flush saturating counters (only with
//               ALUO_ISSUE_PERF_EN defined)
// Optional feature macro: ALUO_ISSUE_PERF_EN
module aluo_issue_reg
  import aluo_issue_reg_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            ex_busy_i,
  aluo_issue_reg_if.slave bus
`ifdef ALUO_ISSUE_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_bubble_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  issue_entry_t in_entry_s;
  issue_entry_t main_d_s;
  issue_entry_t main_q_s;
  issue_entry_t skid_q_s;
  logic         main_valid_s;
  logic         skid_valid_s;
  logic         main_load_s;
  logic         main_clr_s;
  logic         skid_load_s;
  logic         skid_clr_s;
  logic         accept_s;
  logic         skid_valid_nxt_s;
  logic         in_ready_r;

  assign in_entry_s.pc      = bus.in_pc;
  assign in_entry_s.inst    = bus.in_inst;
  assign in_entry_s.itype   = bus.in_type;
  assign in_entry_s.opcode  = bus.in_opcode;
  assign in_entry_s.op1     = bus.in_op1;
  assign in_entry_s.op2     = bus.in_op2;
  assign in_entry_s.rd_ena  = bus.in_rd_ena;
  assign in_entry_s.rd_addr = bus.in_rd_addr;

  assign accept_s = bus.in_valid & in_ready_r;

  // Next-state control: flush, empty main, busy hold, retire
  always_comb begin
    main_load_s = 1'b0;
    main_clr_s  = 1'b0;
    main_d_s    = in_entry_s;
    skid_load_s = 1'b0;
    skid_clr_s  = 1'b0;
    if (flush_i) begin
      // The op in main executes during the flush cycle; nothing is replayed
      main_clr_s = 1'b1;
      skid_clr_s = 1'b1;
    end else if (!main_valid_s) begin
      // Busy is meaningless here and ignored
      if (accept_s) begin
        main_load_s = 1'b1;
      end else begin
        main_load_s = 1'b0;
      end
    end else if (ex_busy_i) begin
      if (accept_s) begin
        skid_load_s = 1'b1;
      end else begin
        skid_load_s = 1'b0;
      end
    end else begin
      if (skid_valid_s) begin
        // in_ready was 0, so nothing new can be accepted this cycle
        main_load_s = 1'b1;
        main_d_s    = skid_q_s;
        skid_clr_s  = 1'b1;
      end else if (accept_s) begin
        main_load_s = 1'b1;
      end else begin
        main_clr_s = 1'b1;
      end
    end
  end

  // Predicted skid occupancy, used to register in_ready
  always_comb begin
    skid_valid_nxt_s = skid_valid_s;
    if (skid_clr_s) begin
      skid_valid_nxt_s = 1'b0;
    end else if (skid_load_s) begin
      skid_valid_nxt_s = 1'b1;
    end else begin
      skid_valid_nxt_s = skid_valid_s;
    end
  end

  // Registered in_ready: no combinational path from busy/flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_r <= 1'b1;
    end else begin
      in_ready_r <= ~skid_valid_nxt_s;
    end
  end

  aluo_issue_entry u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load_s),
    .clr   (main_clr_s),
    .d     (main_d_s),
    .valid (main_valid_s),
    .q     (main_q_s)
  );

  aluo_issue_entry u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load_s),
    .clr   (skid_clr_s),
    .d     (in_entry_s),
    .valid (skid_valid_s),
    .q     (skid_q_s)
  );

  // Main entry payload is already the bubble when invalid
  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = main_valid_s;
  assign bus.out_pc      = main_q_s.pc;
  assign bus.out_inst    = main_q_s.inst;
  assign bus.out_type    = main_q_s.itype;
  assign bus.out_opcode  = main_q_s.opcode;
  assign bus.out_op1     = main_q_s.op1;
  assign bus.out_op2     = main_q_s.op2;
  assign bus.out_rd_ena  = main_q_s.rd_ena;
  assign bus.out_rd_addr = main_q_s.rd_addr;

`ifdef ALUO_ISSUE_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] bubble_cnt_r;
  logic [31:0] flush_cnt_r;

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r  <= 32'd0;
      bubble_cnt_r <= 32'd0;
      flush_cnt_r  <= 32'd0;
    end else begin
      if (main_valid_s && ex_busy_i) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (!main_valid_s) begin
        bubble_cnt_r <= sat_inc(bubble_cnt_r);
      end else begin
        bubble_cnt_r <= bubble_cnt_r;
      end
      // Only flushes that actually discard something are counted
      if (flush_i && (main_valid_s || skid_valid_s)) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign perf_stall_cnt  = stall_cnt_r;
  assign perf_bubble_cnt = bubble_cnt_r;
  assign perf_flush_cnt  = flush_cnt_r;
`endif

endmodule

// File: tb/tb_aluo_issue_reg.sv
// tb_aluo_issue_reg
// Table-driven bench for aluo_issue_reg plus hand-written sequences for the
// busy/skid, full-flush, async-reset and (with ALUO_ISSUE_PERF_EN) counter cases.
module tb_aluo_issue_reg;
  import aluo_issue_reg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush_i = 1'b0;
  logic ex_busy_i = 1'b0;

  aluo_issue_reg_if bus ();

`ifdef ALUO_ISSUE_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_bubble_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  aluo_issue_reg dut (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush_i),
    .ex_busy_i (ex_busy_i),
    .bus       (bus)
`ifdef ALUO_ISSUE_PERF_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_bubble_cnt (perf_bubble_cnt),
    .perf_flush_cnt  (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        vld;
    logic        busy;
    logic        flush;
    logic [7:0]  opc;
    logic [63:0] op1;
    logic        ev;
    logic [7:0]  eopc;
    logic [63:0] eop1;
    logic        erdy;
  } vec_t;

  vec_t vecs [0:15];

  // Payload derived from opcode/op1 so one pair identifies a whole operation
  task automatic drive(input logic v, input logic [7:0] opc, input logic [63:0] op1);
    bus.in_valid   = v;
    bus.in_opcode  = opc;
    bus.in_op1     = op1;
    bus.in_op2     = op1 + 64'd2;
    bus.in_pc      = (op1 << 2) + 64'h1000;
    bus.in_inst    = {24'h5A5A5A, opc};
    bus.in_type    = opc ^ 8'h80;
    bus.in_rd_ena  = 1'b1;
    bus.in_rd_addr = op1[4:0];
  endtask

  function automatic logic [ISSUE_ENTRY_W-1:0] exp_bundle(input logic v, input logic [7:0] opc,
                                                          input logic [63:0] op1);
    logic [ISSUE_ENTRY_W-1:0] b;
    logic [63:0] pc;
    pc = (op1 << 2) + 64'h1000;
    if (v) begin
      b = {pc, {24'h5A5A5A, opc}, opc ^ 8'h80, opc, op1, op1 + 64'd2, 1'b1, op1[4:0]};
    end else begin
      b = '0;
    end
    return b;
  endfunction

  task automatic check_state(input string name, input logic ev, input logic [7:0] eopc,
                             input logic [63:0] eop1, input logic erdy);
    logic [ISSUE_ENTRY_W-1:0] act;
    logic [ISSUE_ENTRY_W-1:0] exp;
    act = {bus.out_pc, bus.out_inst, bus.out_type, bus.out_opcode, bus.out_op1, bus.out_op2,
           bus.out_rd_ena, bus.out_rd_addr};
    exp = exp_bundle(ev, eopc, eop1);
    total++;
    if (bus.out_valid !== ev) begin
      bad++;
      $display("FAIL %s out_valid got=%0b want=%0b", name, bus.out_valid, ev);
    end
    total++;
    if (bus.in_ready !== erdy) begin
      bad++;
      $display("FAIL %s in_ready got=%0b want=%0b", name, bus.in_ready, erdy);
    end
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s payload got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef ALUO_ISSUE_PERF_EN
  task automatic check_cnt(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask
`endif

  initial begin
    // Vector table: inputs for one edge, expected state right after it
    vecs[0] = '{1'b1, 1'b0, 1'b0, OP_ADDI, 64'd5, 1'b1, OP_ADDI, 64'd5, 1'b1};
    for (int i = 1; i <= 8; i++) begin
      logic [7:0] o;
      o = (i % 2 == 1) ? OP_ADD : OP_SUB;
      vecs[i] = '{1'b1, 1'b0, 1'b0, o, 64'd100 + 64'(i), 1'b1, o, 64'd100 + 64'(i), 1'b1};
    end
    vecs[9]  = '{1'b0, 1'b0, 1'b0, OP_ADD, 64'd0, 1'b0, BUBBLE_OPCODE, 64'd0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, OP_ADD, 64'd0, 1'b0, BUBBLE_OPCODE, 64'd0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 1'b0, OP_MUL, 64'd3, 1'b1, OP_MUL, 64'd3, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 1'b0, OP_ADD, 64'd0, 1'b1, OP_MUL, 64'd3, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, OP_ADD, 64'd0, 1'b0, BUBBLE_OPCODE, 64'd0, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 1'b1, OP_ADD, 64'd7, 1'b0, BUBBLE_OPCODE, 64'd0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, OP_ADD, 64'd0, 1'b0, BUBBLE_OPCODE, 64'd0, 1'b1};

    drive(1'b0, OP_ADD, 64'd0);
    #12;
    check_state("reset", 1'b0, BUBBLE_OPCODE, 64'd0, 1'b1);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].vld, vecs[i].opc, vecs[i].op1);
      ex_busy_i = vecs[i].busy;
      flush_i   = vecs[i].flush;
      step();
      check_state($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eopc, vecs[i].eop1, vecs[i].erdy);
    end
    flush_i   = 1'b0;
    ex_busy_i = 1'b0;

    // MUL held 10 busy cycles; ADD parks in skid, SUB waits upstream
    drive(1'b1, OP_MUL, 64'd40);
    step();
    check_state("mul_load", 1'b1, OP_MUL, 64'd40, 1'b1);
    ex_busy_i = 1'b1;
    drive(1'b1, OP_ADD, 64'd41);
    step();
    check_state("mul_busy0", 1'b1, OP_MUL, 64'd40, 1'b0);
    drive(1'b1, OP_SUB, 64'd42);
    for (int i = 1; i < 10; i++) begin
      step();
      check_state($sformatf("mul_busy%0d", i), 1'b1, OP_MUL, 64'd40, 1'b0);
    end
    ex_busy_i = 1'b0;
    step();
    check_state("skid_add", 1'b1, OP_ADD, 64'd41, 1'b1);
    step();
    check_state("then_sub", 1'b1, OP_SUB, 64'd42, 1'b1);
    drive(1'b0, OP_ADD, 64'd0);
    step();
    check_state("drain", 1'b0, BUBBLE_OPCODE, 64'd0, 1'b1);

    // Both entries full, then flush with an op offered
    drive(1'b1, OP_ADD, 64'd50);
    step();
    ex_busy_i = 1'b1;
    drive(1'b1, OP_SUB, 64'd51);
    step();
    check_state("full", 1'b1, OP_ADD, 64'd50, 1'b0);
    flush_i = 1'b1;
    drive(1'b1, OP_CSR, 64'd52);
    step();
    check_state("flush_full", 1'b0, BUBBLE_OPCODE, 64'd0, 1'b1);
    flush_i   = 1'b0;
    ex_busy_i = 1'b0;
    drive(1'b0, OP_ADD, 64'd0);
    step();
    check_state("flush_after", 1'b0, BUBBLE_OPCODE, 64'd0, 1'b1);

    // Async reset mid-cycle while DIV is busy in main
    drive(1'b1, OP_DIV, 64'd60);
    step();
    ex_busy_i = 1'b1;
    drive(1'b0, OP_ADD, 64'd0);
    step();
    check_state("div_busy", 1'b1, OP_DIV, 64'd60, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    check_state("async_rst", 1'b0, BUBBLE_OPCODE, 64'd0, 1'b1);
    ex_busy_i = 1'b0;
    #2;
    rst = 1'b1;
    step();
    check_state("rst_release", 1'b0, BUBBLE_OPCODE, 64'd0, 1'b1);

`ifdef ALUO_ISSUE_PERF_EN
    #2;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    check_cnt("perf_stall_rst", perf_stall_cnt, 32'd0);
    drive(1'b1, OP_MUL, 64'd70);
    step();
    drive(1'b0, OP_ADD, 64'd0);
    ex_busy_i = 1'b1;
    repeat (5) step();
    ex_busy_i = 1'b0;
    step();
    repeat (3) step();
    drive(1'b1, OP_ADD, 64'd71);
    step();
    drive(1'b0, OP_ADD, 64'd0);
    flush_i = 1'b1;
    step();
    step();
    flush_i = 1'b0;
    check_cnt("perf_stall", perf_stall_cnt, 32'd5);
    check_cnt("perf_bubble", perf_bubble_cnt, 32'd6);
    check_cnt("perf_flush", perf_flush_cnt, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aluo_issue_reg.md
Name: aluo_issue_reg

Overview:
- Issue-to-execute pipeline register with a 2-entry skid buffer. Sits directly upstream of the ALUO execution stage and feeds it.
- Holds the current operation stable while ALUO's multi-cycle mul/div is busy (scoreboard busy signal).
- Discards in-flight operations when ALUO raises a trap.
- Presents an explicit bubble encoding to ALUO when it holds no valid operation.

Parameters:
- PC_W, 64, PC and operand width (matches the PC bus)
- INST_W, 32, instruction width
- RADDR_W, 5, register address width

Ports:
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-low
- flush_i  in  1  trap flush from ALUO trap_able
- ex_busy_i  in  1  ALUO mul/div busy (socreboard_aluo)
- in_valid  in  1  issue offers an operation
- in_ready  out  1  this block accepts; registered, equals ~skid_valid
- in_pc  in  64  operation PC
- in_inst  in  32  raw instruction
- in_type  in  8  instruction type; bit 7 = CSR/system class
- in_opcode  in  8  internal opcode
- in_op1  in  64  operand 1
- in_op2  in  64  operand 2
- in_rd_ena  in  1  destination write enable
- in_rd_addr  in  5  destination register
- out_valid  out  1  main entry holds a valid operation
- out_pc, out_inst, out_type, out_opcode, out_op1, out_op2, out_rd_ena, out_rd_addr  out  64/32/8/8/64/64/1/5  drive ALUO pc_i, id_ex_inst, inst_type_i, inst_opcode_i, op1_i, op2_i, rd_ena_i, rd_addr_i

Behaviour:
Storage
- Two entries: main (drives outputs) and skid, each with a valid bit.
- Reset (rst low, async): both valid bits 0, in_ready=1, out_valid=0, all out_* = 0 (the bubble encoding).

Bubble encoding
- Applies whenever main is invalid.
- out_type=0, out_opcode=BUBBLE_OPCODE (8'h00), out_rd_ena=0, out_pc=0, out_inst=0, out_op1=0, out_op2=0.
- BUBBLE_OPCODE must not equal any defined opcode, so ALUO's mul/div/CSR logic stays idle.

Handshake and latency
- Accept = in_valid & in_ready, sampled at the rising edge.
- Latency from accept to out_valid is 1 cycle when main is empty or draining.

Next-state rules, in priority order
- flush_i=1: main and skid are both invalidated. Any operation accepted in the same cycle is dropped. in_ready=1 next cycle.
- Main invalid: an accepted input loads main.
- Main valid, ex_busy_i=1: main holds, and all out_* stay bit-stable. An accepted input loads skid.
- Main valid, ex_busy_i=0: main retires.
  - If skid is valid, main loads skid and skid is cleared. No input is accepted this cycle, because in_ready was 0.
  - Else, an accepted input loads main.
  - Else, main becomes invalid.

Boundary conditions
- Both entries full: in_ready=0. No loss and no duplication.
- ex_busy_i is 0 whenever main is invalid (ALUO only sees the bubble). If it is asserted anyway, it is ignored.
- A trap taken by the operation in main (ecall, timer interrupt): that operation executes during the flush cycle and is not replayed.
- Reset mid mul/div: outputs go to the bubble immediately (async), so ALUO sees no ready request.
- in_ready is a registered output with no combinational path from ex_busy_i or flush_i.

Optional Feature:
- Macro: ALUO_ISSUE_PERF_EN.
- When defined, three outputs are added:
  - perf_stall_cnt (32b): counts cycles with main valid & ex_busy_i.
  - perf_bubble_cnt (32b): counts cycles with main invalid.
  - perf_flush_cnt (32b): counts flush_i cycles that invalidated at least one valid entry.
- All three saturate at 32'hFFFFFFFF and reset to 0.
- When the macro is undefined, these ports and counters do not exist, and the block's behaviour is otherwise identical.

Decomposition:
- Shared defines/package: BUBBLE_OPCODE, entry field widths, and a packed issue-entry struct/concatenation width ISSUE_ENTRY_W = 64+32+8+8+64+64+1+5 = 246.
- One natural sub-module: aluo_issue_entry, a single valid+payload register with load/clear/hold controls. Instantiate it twice (main, skid).

Test Plan:
1. Reset release, then in_valid with ADDI (op1=5, op2=7): out_valid=1 one cycle later with out_opcode=ADDI, out_op1=5, out_op2=7. in_ready stays 1.
2. MUL in main with ex_busy_i=1 for 10 cycles while ADD and SUB are offered back-to-back: ADD goes to skid, in_ready=0 from the next cycle, SUB is held upstream, and MUL outputs stay stable all 10 cycles. After busy drops, out shows ADD then SUB on consecutive cycles.
3. Both entries full and flush_i=1 with in_valid=1: next cycle out_valid=0, outputs are the bubble encoding (opcode 8'h00), in_ready=1, and the offered op never appears.
4. Back-to-back stream of 8 ops with ex_busy_i=0: one op emerges per cycle in order, in_ready stays 1, no gaps.
5. Assert rst low asynchronously mid-cycle while DIV is in main and busy: outputs go to the bubble encoding before the next edge. After release, in_ready=1 and out_valid=0.
6. With ALUO_ISSUE_PERF_EN: 5 busy cycles, 3 idle cycles, and 1 effective flush give perf_stall_cnt=5, perf_bubble_cnt≥3, perf_flush_cnt=1.
